// File: rtl/pipe_skid_register.sv
// Handshake pipeline stage register with a two-entry skid buffer and synchronous flush.
// Optional stall statistics counter is enabled with `define PIPE_STATS_EN.
module pipe_skid_register #(
    parameter int WIDTH = 32
`ifdef PIPE_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
`ifdef PIPE_STATS_EN
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stall_count,
`endif
    output logic [1:0]       dbg_state_o
);

    // Handshake: a beat moves on a rising edge where valid and ready are both high;
    // valid, once raised, holds with stable data until the matching ready is seen.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic               s_ready_q;
    logic               s_xfer;

    assign s_xfer      = s_valid & s_ready_q;
    assign s_ready     = s_ready_q;
    assign m_valid     = (state_q != EMPTY);
    assign m_data      = main_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (s_xfer) begin
                    state_d = BUSY;
                    main_d  = s_data;
                end
            end
            BUSY: begin
                if (m_ready) begin
                    if (s_xfer) begin
                        main_d = s_data;
                    end else begin
                        state_d = EMPTY;
                    end
                end else if (s_xfer) begin
                    state_d = FULL;
                    skid_d  = s_data;
                end
            end
            FULL: begin
                if (m_ready) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops every held beat, including one accepted this cycle.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            s_ready_q <= (state_d != FULL);
        end
    end

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (stat_clr) begin
            stall_d = '0;
        end else if (m_valid && !m_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_register.sv
// Directed and random-back-pressure bench for pipe_skid_register.
// With PIPE_STATS_EN defined the stall counter is built with CNT_W = 4.
module tb_pipe_skid_register;

    localparam int W = 32;
    localparam int N_RAND = 1000;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [1:0]    dbg_state;
`ifdef PIPE_STATS_EN
    logic          stat_clr;
    logic [3:0]    stall_count;
`endif

    int n_tests;
    int n_fail;
    logic [W-1:0] exp_q[$];

    pipe_skid_register #(
        .WIDTH(W)
`ifdef PIPE_STATS_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
`ifdef PIPE_STATS_EN
        .stat_clr(stat_clr),
        .stall_count(stall_count),
`endif
        .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        n_tests++;
        if (m_valid !== 1'b0 || m_data !== 32'h0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: m_valid=%b m_data=%h s_ready=%b, want 0 0 0", m_valid, m_data, s_ready);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_tests++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: s_ready=%b want 0", s_ready);
        end
        tick();
        n_tests++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_edge: s_ready=%b m_valid=%b m_data=%h, want 1 0 0", s_ready, m_valid, m_data);
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] vec [3];
        vec[0] = 32'h11; vec[1] = 32'h22; vec[2] = 32'h33;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = vec[i];
            tick();
            n_tests++;
            if (m_valid !== 1'b1 || m_data !== vec[i]) begin
                n_fail++;
                $display("FAIL stream_beat%0d: m_valid=%b m_data=%h, want 1 %h", i, m_valid, m_data, vec[i]);
            end
        end
        s_valid = 1'b0;
        tick();
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: m_valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_skid();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'hA0;
        tick();
        s_data = 32'hA1;
        tick();
        n_tests++;
        if (s_ready !== 1'b0 || m_data !== 32'hA0 || m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL skid_full: s_ready=%b m_data=%h m_valid=%b, want 0 a0 1", s_ready, m_data, m_valid);
        end
        s_data = 32'hA2;
        tick();
        n_tests++;
        if (s_ready !== 1'b0 || m_data !== 32'hA0) begin
            n_fail++;
            $display("FAIL skid_hold: s_ready=%b m_data=%h, want 0 a0", s_ready, m_data);
        end
        m_ready = 1'b1;
        tick();
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 32'hA1) begin
            n_fail++;
            $display("FAIL skid_drain1: m_valid=%b m_data=%h, want 1 a1", m_valid, m_data);
        end
        tick();
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 32'hA2) begin
            n_fail++;
            $display("FAIL skid_drain2: m_valid=%b m_data=%h, want 1 a2", m_valid, m_data);
        end
        s_valid = 1'b0;
        tick();
        n_tests++;
        if (m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL skid_nodup: m_valid=%b want 0", m_valid);
        end
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h5;
        tick();
        s_data = 32'h6;
        tick();
        n_tests++;
        if (s_ready !== 1'b0 || m_data !== 32'h5) begin
            n_fail++;
            $display("FAIL flush_setup: s_ready=%b m_data=%h, want 0 5", s_ready, m_data);
        end
        flush  = 1'b1;
        s_data = 32'h7;
        tick();
        flush   = 1'b0;
        s_valid = 1'b0;
        n_tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_empty: m_valid=%b s_ready=%b, want 0 1", m_valid, s_ready);
        end
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (m_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_squash%0d: m_valid=%b m_data=%h, want no beat", i, m_valid, m_data);
            end
        end
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h9C;
        tick();
        s_valid = 1'b0;
        n_tests++;
        if (m_valid !== 1'b1 || m_data !== 32'h9C) begin
            n_fail++;
            $display("FAIL async_setup: m_valid=%b m_data=%h, want 1 9c", m_valid, m_data);
        end
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (m_valid !== 1'b0 || m_data !== 32'h0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: m_valid=%b m_data=%h s_ready=%b, want 0 0 0", m_valid, m_data, s_ready);
        end
        tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_recover: s_ready=%b m_valid=%b, want 1 0", s_ready, m_valid);
        end
    endtask

`ifdef PIPE_STATS_EN
    task automatic test_stats();
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        m_ready  = 1'b0;
        s_valid  = 1'b1;
        s_data   = 32'h1;
        tick();
        s_valid = 1'b0;
        repeat (10) tick();
        n_tests++;
        if (stall_count !== 4'd10) begin
            n_fail++;
            $display("FAIL stats_count10: stall_count=%0d want 10", stall_count);
        end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        n_tests++;
        if (stall_count !== 4'd0) begin
            n_fail++;
            $display("FAIL stats_clear: stall_count=%0d want 0", stall_count);
        end
        repeat (20) tick();
        n_tests++;
        if (stall_count !== 4'd15) begin
            n_fail++;
            $display("FAIL stats_saturate: stall_count=%0d want 15", stall_count);
        end
        m_ready = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++;
        if (stall_count !== 4'd15 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stats_flush_keep: stall_count=%0d m_valid=%b, want 15 0", stall_count, m_valid);
        end
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
    endtask
`endif

    task automatic test_random();
        int sent;
        int recv;
        int cycles;
        logic [W-1:0] want;
        sent   = 0;
        recv   = 0;
        cycles = 0;
        exp_q.delete();
        while (recv < N_RAND && cycles < 20000) begin
            s_valid = (sent < N_RAND) && ($urandom_range(0, 3) != 0);
            s_data  = $urandom;
            m_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (m_valid && m_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: m_data=%h with no beat expected", m_data);
                end else begin
                    want = exp_q.pop_front();
                    if (m_data !== want) begin
                        n_fail++;
                        $display("FAIL rand_data%0d: m_data=%h want %h", recv, m_data, want);
                    end
                end
                recv++;
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
                sent++;
            end
            @(posedge clk);
            #1;
            cycles++;
            n_tests++;
            if (m_valid !== (exp_q.size() != 0) || s_ready !== (exp_q.size() < 2)) begin
                n_fail++;
                $display("FAIL rand_flags: m_valid=%b s_ready=%b with %0d held", m_valid, s_ready, exp_q.size());
            end
        end
        s_valid = 1'b0;
        n_tests++;
        if (recv != N_RAND || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_complete: received %0d of %0d, %0d left", recv, N_RAND, exp_q.size());
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
`ifdef PIPE_STATS_EN
        stat_clr = 1'b0;
`endif
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_async_reset();
`ifdef PIPE_STATS_EN
        test_stats();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_skid_register.md
# pipe_skid_register

Parametrised, handshake-controlled pipeline stage register that supersedes the fixed-bundle, enable-only stage registers between pipeline stages. It moves an opaque WIDTH-bit payload from an upstream stage to a downstream stage over valid/ready handshakes. A two-entry skid buffer keeps the upstream ready a registered signal while still sustaining one beat per cycle. A synchronous flush squashes in-flight beats on branch or trap redirect.

## Interface
- WIDTH, 32, payload width in bits; the stage packs data, register address and control signals into it.
- CNT_W, 16, width of the stall statistics counter; present only with PIPE_STATS_EN.
- clk  input  1  clock, all flops rising-edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous squash of all held beats.
- s_valid  input  1  upstream beat valid.
- s_ready  output  1  registered; stage can accept a beat this cycle.
- s_data  input  WIDTH  upstream payload.
- m_valid  output  1  downstream beat valid.
- m_ready  input  1  downstream accepts the beat.
- m_data  output  WIDTH  downstream payload, driven from the main register.
- stat_clr  input  1  synchronous clear of stall_count; PIPE_STATS_EN only.
- stall_count  output  CNT_W  saturating count of back-pressure cycles; PIPE_STATS_EN only.

## Operation
- Storage:
  - Main register `main` drives m_data.
  - Skid register `skid` holds one overflow beat.
- Transfers:
  - Upstream transfer: s_valid & s_ready.
  - Downstream transfer: m_valid & m_ready.
- States (2-bit encoding):
  - EMPTY: nothing held.
  - BUSY: main holds a beat.
  - FULL: main and skid both hold a beat.
- Outputs:
  - m_valid = (state != EMPTY).
  - s_ready is a flop; each cycle it loads (next_state != FULL).
- Transitions when flush = 0:
  - EMPTY, s_valid -> BUSY; main <= s_data.
  - EMPTY, !s_valid -> EMPTY.
  - BUSY, s_valid & m_ready -> BUSY; main <= s_data.
  - BUSY, !s_valid & m_ready -> EMPTY.
  - BUSY, s_valid & !m_ready -> FULL; skid <= s_data.
  - BUSY, !s_valid & !m_ready -> BUSY; main holds.
  - FULL, m_ready -> BUSY; main <= skid. s_ready is 0, so no upstream beat is taken.
  - FULL, !m_ready -> FULL; both registers hold.
- Flush:
  - Highest priority: next state is EMPTY and s_ready loads 1.
  - A beat offered and accepted in the flush cycle is consumed and discarded.
  - Any downstream transfer in the flush cycle completes normally.
- Payload registers load only on the transitions listed above. In EMPTY their content is don't-care, but is zero after reset.
- Beat order is strictly preserved. No beat is duplicated or dropped except by flush.

## Timing
- Values during reset and on the first edge after deassertion:
  - state = EMPTY.
  - main = 0, skid = 0, m_valid = 0, m_data = 0.
  - s_ready = 0 during reset; it becomes 1 at the first rising edge after reset deasserts.
  - stall_count = 0.
- Latency is 1 cycle: a beat accepted at edge N is on m_data/m_valid after edge N.
- Throughput:
  - 1 beat/cycle while m_ready is held high.
  - Under back-pressure, the stage absorbs exactly one extra beat, then s_ready drops on the next edge.
- s_ready depends only on flops. There is no combinational path from m_ready to s_ready.
- m_data and m_valid come only from flops. There is no combinational path from any input.
- Reset asserted mid-operation discards all held beats immediately, asynchronously.

## Configuration
- PIPE_STATS_EN:
  - Defined: adds stat_clr, stall_count and the CNT_W parameter.
  - stall_count increments on each cycle with m_valid & !m_ready and saturates at 2^CNT_W-1.
  - stat_clr clears it to 0 and has priority over increment.
  - flush does not clear stall_count.
  - Undefined: the ports, parameter and counter logic are absent. Handshake behaviour is identical in both builds.

## Test plan
- Reset then stream:
  - Stimulus: hold reset 3 cycles, release; after s_ready rises, drive s_data 0x11, 0x22, 0x33 back-to-back with m_ready = 1.
  - Required: m_data shows 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after acceptance; m_valid drops the cycle after the last beat.
- Skid fill:
  - Stimulus: with 0xA0 in main, drive m_ready = 0 and offer 0xA1, then 0xA2.
  - Required: 0xA1 is accepted into skid; s_ready is 0 on the next edge; 0xA2 is not accepted.
  - Stimulus: raise m_ready.
  - Required: 0xA0, 0xA1, 0xA2 emerge in order with no gaps after release.
- Flush in FULL:
  - Stimulus: reach FULL holding 0x5, 0x6; pulse flush with s_valid = 1 and s_data = 0x7.
  - Required: next cycle m_valid = 0 and s_ready = 1; none of 0x5, 0x6, 0x7 ever appears at m_data.
- Async reset mid-stream:
  - Stimulus: assert reset between edges while in BUSY.
  - Required: m_valid = 0 and m_data = 0 immediately, without waiting for a clock edge.
- Random back-pressure:
  - Stimulus: 1000 beats with random s_valid and m_ready.
  - Required: the scoreboard sees all beats, in order, with no duplicates.
- PIPE_STATS_EN:
  - Stimulus: hold m_ready = 0 for 10 cycles with m_valid = 1.
  - Required: stall_count = 10.
  - Stimulus: pulse stat_clr.
  - Required: stall_count = 0.
  - Stimulus: build with CNT_W = 4 and hold the stall for 20 cycles.
  - Required: stall_count saturates at 15.
